// File: rtl/idex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and NOP-forcing control output. Optional bubble counter: IDEX_BUBBLE_CNT_EN.
module idex_pipe_stage #(
    parameter int DATA_W   = 16,
    parameter int NUM_DATA = 5,
    parameter int CTRL_W   = 14,
    parameter int REG_W    = 4,
    parameter int NUM_REG  = 2
`ifdef IDEX_BUBBLE_CNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0]  in_data,
    input  logic [NUM_REG*REG_W-1:0]    in_reg,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0]  out_data,
    output logic [NUM_REG*REG_W-1:0]    out_reg
`ifdef IDEX_BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0]            bubble_cnt
`endif
);

    localparam int PAY_W = NUM_DATA * DATA_W;
    localparam int SPC_W = NUM_REG * REG_W;

    logic              mainVld_p0, skidVld_p0, inReady_p0;
    logic [CTRL_W-1:0] mainCtrl_p0, skidCtrl_p0;
    logic [PAY_W-1:0]  mainData_p0, skidData_p0;
    logic [SPC_W-1:0]  mainReg_p0, skidReg_p0;

    logic              mainVldNxt, skidVldNxt, inReadyNxt;
    logic [CTRL_W-1:0] mainCtrlNxt, skidCtrlNxt;
    logic [PAY_W-1:0]  mainDataNxt, skidDataNxt;
    logic [SPC_W-1:0]  mainRegNxt, skidRegNxt;
    logic              accept, consume;

    assign accept  = in_valid & inReady_p0;
    assign consume = mainVld_p0 & out_ready;

    always_comb begin
        mainVldNxt  = mainVld_p0;
        mainCtrlNxt = mainCtrl_p0;
        mainDataNxt = mainData_p0;
        mainRegNxt  = mainReg_p0;
        skidVldNxt  = skidVld_p0;
        skidCtrlNxt = skidCtrl_p0;
        skidDataNxt = skidData_p0;
        skidRegNxt  = skidReg_p0;

        // Flush drops both entries; payload is left stale since it is masked by valid.
        if (flush) begin
            mainVldNxt = 1'b0;
            skidVldNxt = 1'b0;
        end else if (!mainVld_p0) begin
            if (accept) begin
                mainVldNxt  = 1'b1;
                mainCtrlNxt = in_ctrl;
                mainDataNxt = in_data;
                mainRegNxt  = in_reg;
            end
        end else if (consume) begin
            if (skidVld_p0) begin
                mainCtrlNxt = skidCtrl_p0;
                mainDataNxt = skidData_p0;
                mainRegNxt  = skidReg_p0;
                if (accept) begin
                    skidCtrlNxt = in_ctrl;
                    skidDataNxt = in_data;
                    skidRegNxt  = in_reg;
                end else begin
                    skidVldNxt = 1'b0;
                end
            end else if (accept) begin
                mainCtrlNxt = in_ctrl;
                mainDataNxt = in_data;
                mainRegNxt  = in_reg;
            end else begin
                mainVldNxt = 1'b0;
            end
        end else if (accept) begin
            // in_ready was high, so the skid slot is known to be free.
            skidVldNxt  = 1'b1;
            skidCtrlNxt = in_ctrl;
            skidDataNxt = in_data;
            skidRegNxt  = in_reg;
        end

        inReadyNxt = !skidVldNxt;
    end

    // ---- stage p0 register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mainVld_p0  <= 1'b0;
            skidVld_p0  <= 1'b0;
            inReady_p0  <= 1'b1;
            mainCtrl_p0 <= '0;
            mainData_p0 <= '0;
            mainReg_p0  <= '0;
            skidCtrl_p0 <= '0;
            skidData_p0 <= '0;
            skidReg_p0  <= '0;
        end else begin
            mainVld_p0  <= mainVldNxt;
            skidVld_p0  <= skidVldNxt;
            inReady_p0  <= inReadyNxt;
            mainCtrl_p0 <= mainCtrlNxt;
            mainData_p0 <= mainDataNxt;
            mainReg_p0  <= mainRegNxt;
            skidCtrl_p0 <= skidCtrlNxt;
            skidData_p0 <= skidDataNxt;
            skidReg_p0  <= skidRegNxt;
        end
    end

    assign in_ready  = inReady_p0;
    assign out_valid = mainVld_p0;
    assign out_ctrl  = mainVld_p0 ? mainCtrl_p0 : '0;
    assign out_data  = mainData_p0;
    assign out_reg   = mainReg_p0;

`ifdef IDEX_BUBBLE_CNT_EN
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0] bubbleCnt_p0;

    // Counts cycles where execute could consume but nothing is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubbleCnt_p0 <= '0;
        end else if (out_ready && !mainVld_p0) begin
            bubbleCnt_p0 <= satInc(bubbleCnt_p0);
        end
    end

    assign bubble_cnt = bubbleCnt_p0;
`endif

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Directed + randomized scoreboard bench for idex_pipe_stage (bubble counter checked
// when IDEX_BUBBLE_CNT_EN is defined).
module tb_idex_pipe_stage;

    localparam int DATA_W   = 16;
    localparam int NUM_DATA = 5;
    localparam int CTRL_W   = 14;
    localparam int REG_W    = 4;
    localparam int NUM_REG  = 2;
    localparam int PAY_W    = NUM_DATA * DATA_W;
    localparam int SPC_W    = NUM_REG * REG_W;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [PAY_W-1:0]  in_data, out_data;
    logic [SPC_W-1:0]  in_reg, out_reg;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [PAY_W-1:0]  d;
        logic [SPC_W-1:0]  r;
    } ent_t;

    ent_t sb[$];
    int   nChecks = 0;
    int   nFail   = 0;
    logic held    = 1'b0;

    always #5 clk = ~clk;

`ifdef IDEX_BUBBLE_CNT_EN
    logic [3:0] bubble_cnt;
    idex_pipe_stage #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CTRL_W(CTRL_W),
                      .REG_W(REG_W), .NUM_REG(NUM_REG), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_reg(in_reg), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .out_reg(out_reg),
        .bubble_cnt(bubble_cnt));
`else
    idex_pipe_stage #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CTRL_W(CTRL_W),
                      .REG_W(REG_W), .NUM_REG(NUM_REG)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_reg(in_reg), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .out_reg(out_reg));
`endif

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input logic v, input logic [15:0] val, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_data  = {NUM_DATA{val}};
        in_reg   = val[SPC_W-1:0];
        in_ctrl  = c;
    endtask

    // Scoreboard one clock: settle, score transfers, then advance to 1 time unit after the edge.
    task automatic cycle();
        ent_t e;
        #4;
        held = 1'b0;
        if (rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spuriousOut", {127'd0, out_valid}, 128'd0);
                end else begin
                    e = sb.pop_front();
                    chk("outCtrl", {114'd0, out_ctrl}, {114'd0, e.c});
                    chk("outData", {48'd0, out_data}, {48'd0, e.d});
                    chk("outReg", {120'd0, out_reg}, {120'd0, e.r});
                end
            end
            if (!out_valid) chk("bubbleCtrl", {114'd0, out_ctrl}, 128'd0);
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                e.c = in_ctrl; e.d = in_data; e.r = in_reg;
                sb.push_back(e);
            end else if (in_valid) begin
                held = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        setIn(1'b0, 16'h0, '0);

        // Reset
        @(posedge clk); #1;
        cycle(); cycle();
        chk("rstValid", {127'd0, out_valid}, 128'd0);
        chk("rstCtrl", {114'd0, out_ctrl}, 128'd0);
        chk("rstData", {48'd0, out_data}, 128'd0);
        chk("rstReg", {120'd0, out_reg}, 128'd0);
        chk("rstReady", {127'd0, in_ready}, 128'd1);
`ifdef IDEX_BUBBLE_CNT_EN
        chk("rstBubble", {124'd0, bubble_cnt}, 128'd0);
`endif
        rst = 1'b1;

        // Streaming
        out_ready = 1'b1;
        setIn(1'b1, 16'h1234, 14'h3FFF); cycle();
        chk("latency1", {127'd0, out_valid}, 128'd1);
        chk("streamReady0", {127'd0, in_ready}, 128'd1);
        setIn(1'b1, 16'h1122, 14'h3FFF); cycle();
        chk("streamReady1", {127'd0, in_ready}, 128'd1);
        setIn(1'b1, 16'h0000, 14'h3FFF); cycle();
        chk("streamReady2", {127'd0, in_ready}, 128'd1);
        setIn(1'b1, 16'h1111, 14'h3FFF); cycle();
        chk("streamReady3", {127'd0, in_ready}, 128'd1);
        setIn(1'b0, 16'h0, '0); cycle(); cycle();
        chk("streamDrained", {127'd0, out_valid}, 128'd0);

        // Backpressure
        out_ready = 1'b0;
        setIn(1'b1, 16'hAAAA, 14'h2AAA); cycle();
        setIn(1'b1, 16'hBBBB, 14'h1BBB); cycle();
        chk("bpReadyLow", {127'd0, in_ready}, 128'd0);
        chk("bpHoldA", {48'd0, out_data}, {48'd0, {NUM_DATA{16'hAAAA}}});
        setIn(1'b0, 16'h0, '0); cycle();
        chk("bpHoldA2", {48'd0, out_data}, {48'd0, {NUM_DATA{16'hAAAA}}});
        chk("bpReadyLow2", {127'd0, in_ready}, 128'd0);
        out_ready = 1'b1; cycle();
        chk("bpReadyBack", {127'd0, in_ready}, 128'd1);
        chk("bpNextB", {48'd0, out_data}, {48'd0, {NUM_DATA{16'hBBBB}}});
        cycle();
        chk("bpDrained", {127'd0, out_valid}, 128'd0);

        // Flush with both entries held and a colliding accept
        out_ready = 1'b0;
        setIn(1'b1, 16'hAAAA, 14'h2AAA); cycle();
        setIn(1'b1, 16'hBBBB, 14'h1BBB); cycle();
        flush = 1'b1;
        setIn(1'b1, 16'hCCCC, 14'h0CCC); cycle();
        flush = 1'b0;
        setIn(1'b0, 16'h0, '0);
        chk("flValid", {127'd0, out_valid}, 128'd0);
        chk("flCtrl", {114'd0, out_ctrl}, 128'd0);
        chk("flReady", {127'd0, in_ready}, 128'd1);
        out_ready = 1'b1; cycle(); cycle(); cycle();

        // Flush coinciding with a consume
        out_ready = 1'b0;
        setIn(1'b1, 16'hAAAA, 14'h2AAA); cycle();
        setIn(1'b1, 16'hBBBB, 14'h1BBB); cycle();
        out_ready = 1'b1; flush = 1'b1;
        setIn(1'b1, 16'hCCCC, 14'h0CCC); cycle();
        flush = 1'b0;
        setIn(1'b0, 16'h0, '0);
        chk("flConsValid", {127'd0, out_valid}, 128'd0);
        cycle(); cycle();

        // Random traffic; upstream holds an unaccepted entry
        for (int i = 0; i < 80; i++) begin
            if (!held) setIn(1'($urandom_range(0, 1)), 16'($urandom), 14'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        setIn(1'b0, 16'h0, '0);
        out_ready = 1'b1;
        cycle(); cycle(); cycle();
        chk("randNoLoss", 128'(sb.size()), 128'd0);

        // Async reset mid-stream
        out_ready = 1'b0;
        setIn(1'b1, 16'h5A5A, 14'h1234); cycle();
        setIn(1'b0, 16'h0, '0);
        chk("arPreValid", {127'd0, out_valid}, 128'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arValid", {127'd0, out_valid}, 128'd0);
        chk("arCtrl", {114'd0, out_ctrl}, 128'd0);
        chk("arReady", {127'd0, in_ready}, 128'd1);
        sb.delete();
        @(posedge clk); #1;
        cycle();
        rst = 1'b1;
        out_ready = 1'b1;
        setIn(1'b1, 16'h6789, 14'h0ABC); cycle();
        chk("arResume", {127'd0, out_valid}, 128'd1);
        setIn(1'b0, 16'h0, '0); cycle();
        chk("arDrained", 128'(sb.size()), 128'd0);

`ifdef IDEX_BUBBLE_CNT_EN
        // Bubble counter from a fresh reset
        out_ready = 1'b0;
        rst = 1'b0;
        cycle(); cycle();
        rst = 1'b1;
        out_ready = 1'b1;
        cycle(); cycle(); cycle();
        flush = 1'b1; cycle();
        flush = 1'b0;
        chk("bubble4", {124'd0, bubble_cnt}, 128'd4);
        for (int i = 0; i < 20; i++) cycle();
        chk("bubbleSat", {124'd0, bubble_cnt}, 128'd15);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
